// File: rtl/neuron_mode_fst_mc_pkg.sv
// -----------------------------------------------------------------------------
// neuron_mode_fst_mc_pkg
// Shared definitions for the multi-channel first-spike-time encoder:
//   - output word type codes (spike / activity) and type field width
//   - field offsets of the emitted word {1'b1, type, ch, time}
//   - channel-index width helper
// -----------------------------------------------------------------------------
package neuron_mode_fst_mc_pkg;

    // Width of the type field inside an emitted word.
    localparam int NEURON_TYPE_W = 3;

    // Type codes carried in the output word.
    localparam logic [NEURON_TYPE_W-1:0] NEURON_TYPE_SPIKE = 3'd1;
    localparam logic [NEURON_TYPE_W-1:0] NEURON_TYPE_ACT   = 3'd2;

    // Source of the next word loaded into the output register.
    typedef enum logic [1:0] {
        SRC_HOLD  = 2'd0,
        SRC_NONE  = 2'd1,
        SRC_SPIKE = 2'd2,
        SRC_ACT   = 2'd3
    } neuron_src_e;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int neuron_ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Word layout, LSB first: time, channel, type, marker bit.
    function automatic int neuron_ch_lsb(input int out_t_w);
        return out_t_w;
    endfunction

    function automatic int neuron_type_lsb(input int ch_w, input int out_t_w);
        return out_t_w + ch_w;
    endfunction

    function automatic int neuron_out_w(input int ch_w, input int out_t_w);
        return 1 + NEURON_TYPE_W + ch_w + out_t_w;
    endfunction

endpackage

// File: rtl/neuron_mode_fst_mc_if.sv
// -----------------------------------------------------------------------------
// neuron_mode_fst_mc_if
// Valid/ready output word stream of the FST encoder.
//   out_valid : word on out_data is valid      (master -> slave)
//   out_ready : consumer accepts the word      (slave  -> master)
//   out_data  : {1'b1, type, ch, time}          (master -> slave)
// -----------------------------------------------------------------------------
interface neuron_mode_fst_mc_if #(
    parameter int DATA_W = 10
) ();
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/neuron_fst_prio_enc.sv
// -----------------------------------------------------------------------------
// neuron_fst_prio_enc
// Lowest-set-bit encoder used to pick the next pending channel.
//   req : N-bit request vector
//   any : at least one request bit set
//   idx : index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module neuron_fst_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan upward; the first set bit found wins and later bits are ignored.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = (req[i] && !any) ? W'(i) : idx;
            any = any | req[i];
        end
    end

endmodule

// File: rtl/neuron_mode_fst_mc.sv
// -----------------------------------------------------------------------------
// neuron_mode_fst_mc
// Multi-channel registered first-spike-time encoder. One shared time counter
// advances on ticks after arm; each armed channel latches the time of its first
// spike (or times out at T_LIMIT) and disarms. Latched spikes and per-tick
// activity words leave through a valid/ready output register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   arm          : start a new window (t=0, all channels armed)
//   tick         : advance time by one step (saturates at T_LIMIT)
//   spike_in     : per-channel spike strobes
//   stream_act   : request one activity word on this tick
//   out_if       : output word stream (valid/ready/data)
//   post_spike   : combinational pulse per first spike accepted this cycle
//   armed_o      : registered armed flags
//   window_done  : nothing armed, nothing pending, output register empty
//   act_drop     : one-cycle pulse when an activity request merges/is lost
// -----------------------------------------------------------------------------
module neuron_mode_fst_mc
    import neuron_mode_fst_mc_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int T_W     = 8,
    parameter int OUT_T_W = 4,
    parameter int T_LIMIT = 255,
    parameter int TO_EN   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                tick,
    input  logic [N_CH-1:0]     spike_in,
    input  logic                stream_act,
    neuron_mode_fst_mc_if.master out_if,
    output logic [N_CH-1:0]     post_spike,
    output logic [N_CH-1:0]     armed_o,
    output logic                window_done,
    output logic                act_drop
);

    localparam int CH_W     = neuron_ch_w(N_CH);
    localparam int CH_LSB   = neuron_ch_lsb(OUT_T_W);
    localparam int TYPE_LSB = neuron_type_lsb(CH_W, OUT_T_W);
    localparam int OUT_W    = neuron_out_w(CH_W, OUT_T_W);
    localparam logic [T_W-1:0] T_MAX = T_W'(T_LIMIT);

    // Saturate a time value into the output payload; all ones also flags
    // timeouts and late spikes.
    function automatic logic [OUT_T_W-1:0] sat_time(input logic [T_W-1:0] x);
        if (32'(x) >= (32'd1 << OUT_T_W)) begin
            return '1;
        end else begin
            return OUT_T_W'(x);
        end
    endfunction

    function automatic logic [OUT_W-1:0] pack_word(
        input logic [NEURON_TYPE_W-1:0] typ,
        input logic [CH_W-1:0]          ch,
        input logic [OUT_T_W-1:0]       tm
    );
        logic [OUT_W-1:0] w;
        w = '0;
        w[0 +: OUT_T_W]             = tm;
        w[CH_LSB +: CH_W]           = ch;
        w[TYPE_LSB +: NEURON_TYPE_W] = typ;
        w[OUT_W-1]                  = 1'b1;
        return w;
    endfunction

    logic [T_W-1:0]     t_r;
    logic [N_CH-1:0]    armed_r;
    logic [N_CH-1:0]    pend_r;
    logic [T_W-1:0]     lt_r [N_CH];
    logic               act_pend_r;
    logic               out_valid_r;
    logic [OUT_W-1:0]   out_data_r;
    logic               act_drop_r;

    logic [N_CH-1:0]    acc_s;
    logic [N_CH-1:0]    to_mask_s;
    logic [N_CH-1:0]    new_pend_s;
    logic [N_CH-1:0]    pend_eff_s;
    logic [N_CH-1:0]    pend_next_s;
    logic [N_CH-1:0]    sel_mask_s;
    logic               prio_any_s;
    logic [CH_W-1:0]    prio_idx_s;
    logic [T_W-1:0]     sel_time_s;
    logic [T_W-1:0]     t_next_s;
    logic               load_en_s;
    logic               act_left_s;
    logic               act_req_s;
    logic               act_pend_next_s;
    logic               act_drop_next_s;
    neuron_src_e        src_s;

    // Pending set includes this cycle's new spikes/timeouts so a spike can
    // reach the output register in the very next cycle.
    neuron_fst_prio_enc #(
        .N (N_CH),
        .W (CH_W)
    ) u_prio (
        .req (pend_eff_s),
        .any (prio_any_s),
        .idx (prio_idx_s)
    );

    // Next-state decode: accepted spikes, timeouts, load selection, activity.
    always_comb begin
        acc_s = spike_in & armed_r & {N_CH{~arm}};

        if ((TO_EN != 0) && (t_r == T_MAX) && !arm) begin
            to_mask_s = armed_r;
        end else begin
            to_mask_s = '0;
        end

        new_pend_s = acc_s | to_mask_s;
        pend_eff_s = pend_r | new_pend_s;
        load_en_s  = ~out_valid_r | out_if.out_ready;
        sel_mask_s = N_CH'(1'b1) << prio_idx_s;

        // A channel pending from earlier cycles uses its latched time; a
        // channel latching this cycle uses the current (pre-tick) time.
        if (pend_r[prio_idx_s]) begin
            sel_time_s = lt_r[prio_idx_s];
        end else begin
            sel_time_s = t_r;
        end

        if (tick && (t_r < T_MAX)) begin
            t_next_s = t_r + 1'b1;
        end else begin
            t_next_s = t_r;
        end

        src_s       = SRC_HOLD;
        pend_next_s = pend_eff_s;
        act_left_s  = act_pend_r;
        if (load_en_s) begin
            if (prio_any_s) begin
                src_s       = SRC_SPIKE;
                pend_next_s = pend_eff_s & ~sel_mask_s;
            end else if (act_pend_r) begin
                src_s      = SRC_ACT;
                act_left_s = 1'b0;
            end else begin
                src_s = SRC_NONE;
            end
        end else begin
            src_s = SRC_HOLD;
        end

        // A new request on top of an unconsumed one merges and is reported.
        act_req_s       = tick & stream_act;
        act_pend_next_s = act_req_s | act_left_s;
        act_drop_next_s = act_req_s & act_left_s;
    end

    // All encoder state: time, armed/pending flags, latched times, output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_r         <= '0;
            armed_r     <= '0;
            pend_r      <= '0;
            act_pend_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            act_drop_r  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                lt_r[i] <= '0;
            end
        end else if (arm) begin
            // arm discards pending work but never drops a word already offered.
            t_r        <= '0;
            armed_r    <= '1;
            pend_r     <= '0;
            act_pend_r <= 1'b0;
            act_drop_r <= 1'b0;
            if (load_en_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end else begin
            t_r        <= t_next_s;
            armed_r    <= armed_r & ~new_pend_s;
            pend_r     <= pend_next_s;
            act_pend_r <= act_pend_next_s;
            act_drop_r <= act_drop_next_s;
            for (int i = 0; i < N_CH; i++) begin
                if (new_pend_s[i]) begin
                    lt_r[i] <= t_r;
                end else begin
                    lt_r[i] <= lt_r[i];
                end
            end
            case (src_s)
                SRC_SPIKE: begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= pack_word(NEURON_TYPE_SPIKE, prio_idx_s, sat_time(sel_time_s));
                end
                SRC_ACT: begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= pack_word(NEURON_TYPE_ACT, '0, sat_time(t_r));
                end
                SRC_NONE: begin
                    out_valid_r <= 1'b0;
                end
                default: begin
                    out_valid_r <= out_valid_r;
                end
            endcase
        end
    end

    assign post_spike       = acc_s;
    assign armed_o          = armed_r;
    assign act_drop         = act_drop_r;
    assign window_done      = (armed_r == '0) && (pend_r == '0) && !out_valid_r;
    assign out_if.out_valid = out_valid_r;
    assign out_if.out_data  = out_data_r;

endmodule
